// File: rtl/uart_link_scheduler.sv
// Shares one UART TX/RX FIFO pair between NUM_CH message channels using tag/data byte framing.
// Optional RX silence watchdog is built when LINK_TIMEOUT_EN is defined.
module uart_link_scheduler #(
    parameter int unsigned NUM_CH         = 3,
    parameter logic [7:0]  TAG_BASE       = 8'hA0,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     req,
    input  logic [8*NUM_CH-1:0]   req_data,
    output logic [NUM_CH-1:0]     req_ack,
    input  logic                  tx_full,
    output logic [7:0]            send_uart,
    output logic                  wr_uart,
    input  logic                  rx_empty,
    input  logic [7:0]            get_uart,
    output logic                  rd_uart,
    output logic [8*NUM_CH-1:0]   rx_data,
    output logic [NUM_CH-1:0]     rx_valid,
    output logic                  frame_err,
    output logic                  link_lost
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {TX_IDLE, TX_TAG, TX_GAP, TX_DATA} tx_state_t;
    typedef enum logic {RX_TAG, RX_DATA} rx_state_t;

    // ---------------------------------------------------------------- TX side
    tx_state_t         tx_state, tx_state_nxt;
    logic [CH_W-1:0]   tx_ch, tx_ch_nxt;
    logic [7:0]        tx_byte, tx_byte_nxt;
    logic [CH_W-1:0]   ptr, ptr_nxt;
    logic              wr_nxt;
    logic [7:0]        send_nxt;
    logic [NUM_CH-1:0] ack_nxt;

    logic [7:0]        req_byte [NUM_CH];
    logic              grant_vld;
    logic [CH_W-1:0]   grant_ch;
    logic [CH_W-1:0]   cand_ch;
    int unsigned       cand;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            req_byte[i] = req_data[8*i +: 8];
        end
    end

    // Round-robin search starting one past the last served channel.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        cand      = 0;
        cand_ch   = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            cand_ch = CH_W'(cand);
            if (!grant_vld && req[cand_ch]) begin
                grant_vld = 1'b1;
                grant_ch  = cand_ch;
            end
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_ch_nxt    = tx_ch;
        tx_byte_nxt  = tx_byte;
        ptr_nxt      = ptr;
        wr_nxt       = 1'b0;
        send_nxt     = 8'h00;
        ack_nxt      = '0;
        case (tx_state)
            TX_IDLE: begin
                if (grant_vld) begin
                    tx_ch_nxt    = grant_ch;
                    tx_byte_nxt  = req_byte[grant_ch];
                    tx_state_nxt = TX_TAG;
                end
            end
            TX_TAG: begin
                if (!tx_full) begin
                    wr_nxt       = 1'b1;
                    send_nxt     = TAG_BASE | 8'(tx_ch);
                    tx_state_nxt = TX_GAP;
                end
            end
            // Idle cycle so tx_full can account for the tag just written.
            TX_GAP: begin
                tx_state_nxt = TX_DATA;
            end
            TX_DATA: begin
                if (!tx_full) begin
                    wr_nxt       = 1'b1;
                    send_nxt     = tx_byte;
                    ack_nxt      = NUM_CH'(1) << tx_ch;
                    ptr_nxt      = tx_ch;
                    tx_state_nxt = TX_IDLE;
                end
            end
            default: begin
                tx_state_nxt = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state  <= TX_IDLE;
            tx_ch     <= '0;
            tx_byte   <= 8'h00;
            ptr       <= CH_W'(NUM_CH - 1);
            wr_uart   <= 1'b0;
            send_uart <= 8'h00;
            req_ack   <= '0;
        end else begin
            tx_state  <= tx_state_nxt;
            tx_ch     <= tx_ch_nxt;
            tx_byte   <= tx_byte_nxt;
            ptr       <= ptr_nxt;
            wr_uart   <= wr_nxt;
            send_uart <= send_nxt;
            req_ack   <= ack_nxt;
        end
    end

    // ---------------------------------------------------------------- RX side
    rx_state_t         rx_state, rx_state_nxt;
    logic [CH_W-1:0]   rx_ch, rx_ch_nxt;
    logic [7:0]        rx_reg [NUM_CH];
    logic [7:0]        rx_reg_nxt [NUM_CH];
    logic              rd_nxt;
    logic [NUM_CH-1:0] rx_valid_nxt;
    logic              ferr_nxt;
    logic              settle;

    always_comb begin
        rx_state_nxt = rx_state;
        rx_ch_nxt    = rx_ch;
        rx_reg_nxt   = rx_reg;
        rd_nxt       = 1'b0;
        rx_valid_nxt = '0;
        ferr_nxt     = 1'b0;
        // The FIFO head is only trusted once the previous pop has fully settled.
        if (!rx_empty && !rd_uart && !settle) begin
            rd_nxt = 1'b1;
            case (rx_state)
                RX_TAG: begin
                    if ((get_uart[7:4] == TAG_BASE[7:4]) && (32'(get_uart[3:0]) < NUM_CH)) begin
                        rx_ch_nxt    = CH_W'(get_uart[3:0]);
                        rx_state_nxt = RX_DATA;
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                end
                RX_DATA: begin
                    rx_reg_nxt[rx_ch] = get_uart;
                    rx_valid_nxt      = NUM_CH'(1) << rx_ch;
                    rx_state_nxt      = RX_TAG;
                end
                default: begin
                    rx_state_nxt = RX_TAG;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state  <= RX_TAG;
            rx_ch     <= '0;
            rx_reg    <= '{default: 8'h00};
            rd_uart   <= 1'b0;
            rx_valid  <= '0;
            frame_err <= 1'b0;
            settle    <= 1'b0;
        end else begin
            rx_state  <= rx_state_nxt;
            rx_ch     <= rx_ch_nxt;
            rx_reg    <= rx_reg_nxt;
            rd_uart   <= rd_nxt;
            rx_valid  <= rx_valid_nxt;
            frame_err <= ferr_nxt;
            settle    <= rd_uart;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            rx_data[8*i +: 8] = rx_reg[i];
        end
    end

    // ---------------------------------------------------------------- RX watchdog
`ifdef LINK_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt, to_cnt_nxt;

    always_comb begin
        to_cnt_nxt = to_cnt;
        if (|rx_valid) begin
            to_cnt_nxt = '0;
        end else if (to_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
            to_cnt_nxt = to_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt    <= '0;
            link_lost <= 1'b0;
        end else begin
            to_cnt    <= to_cnt_nxt;
            link_lost <= (to_cnt_nxt == CNT_W'(TIMEOUT_CYCLES));
        end
    end
`else
    assign link_lost = 1'b0;
`endif

endmodule

// File: tb/tb_uart_link_scheduler.sv
// Directed scoreboard bench for uart_link_scheduler (NUM_CH=3, TAG_BASE=A0, TIMEOUT_CYCLES=100).
module tb_uart_link_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [23:0] req_data;
    logic [2:0]  req_ack;
    logic        tx_full;
    logic [7:0]  send_uart;
    logic        wr_uart;
    logic        rx_empty = 1'b1;
    logic [7:0]  get_uart = 8'h00;
    logic        rd_uart;
    logic [23:0] rx_data;
    logic [2:0]  rx_valid;
    logic        frame_err;
    logic        link_lost;

    always #5 clk = ~clk;

    uart_link_scheduler #(
        .NUM_CH(3),
        .TAG_BASE(8'hA0),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_ack(req_ack),
        .tx_full(tx_full), .send_uart(send_uart), .wr_uart(wr_uart),
        .rx_empty(rx_empty), .get_uart(get_uart), .rd_uart(rd_uart),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .link_lost(link_lost)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {logic [7:0] b; logic [2:0] ack;} tx_exp_t;
    typedef struct packed {logic [2:0] vld; logic ferr; logic [1:0] ch; logic [7:0] d;} rx_exp_t;

    tx_exp_t    tx_exp [$];
    rx_exp_t    rx_exp [$];
    logic [7:0] rx_q   [$];

    // RX FIFO model: show-ahead head, popped on rd_uart.
    always @(posedge clk) begin
        if (rd_uart && rx_q.size() > 0) void'(rx_q.pop_front());
    end
    always @(negedge clk) begin
        rx_empty = (rx_q.size() == 0);
        get_uart = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end

    logic prev_wr = 1'b0;
    always @(negedge clk) begin
        tx_exp_t e;
        if (wr_uart) begin
            check("tx_strobe_gap", 32'(prev_wr), 32'd0);
            n_cmp++;
            assert (tx_exp.size() != 0) else begin
                n_fail++;
                $error("FAIL tx_unexpected: observed %0h expected none", send_uart);
            end
            if (tx_exp.size() != 0) begin
                e = tx_exp.pop_front();
                check("tx_byte", 32'(send_uart), 32'(e.b));
                check("tx_ack", 32'(req_ack), 32'(e.ack));
            end
        end else begin
            check("tx_quiet", 32'({send_uart, req_ack}), 32'd0);
        end
        prev_wr = wr_uart;
    end

    always @(negedge clk) begin
        rx_exp_t e;
        if (rx_valid != 3'b000 || frame_err) begin
            n_cmp++;
            assert (rx_exp.size() != 0) else begin
                n_fail++;
                $error("FAIL rx_unexpected: observed %0h expected none", {rx_valid, frame_err});
            end
            if (rx_exp.size() != 0) begin
                e = rx_exp.pop_front();
                check("rx_flags", 32'({rx_valid, frame_err}), 32'({e.vld, e.ferr}));
                if (e.vld != 3'b000) check("rx_data", 32'(rx_data[8*e.ch +: 8]), 32'(e.d));
            end
        end
    end

    int unsigned tb_ptr;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int unsigned pick(input logic [2:0] m);
        for (int unsigned i = 1; i <= 3; i++) begin
            int unsigned c = (tb_ptr + i) % 3;
            if (m[c[1:0]]) return c;
        end
        return 0;
    endfunction

    task automatic expect_frame(input int unsigned c, input logic [7:0] d);
        tx_exp.push_back('{b: 8'hA0 | 8'(c), ack: 3'b000});
        tx_exp.push_back('{b: d, ack: 3'(1 << c)});
        tb_ptr = c;
    endtask

    task automatic wait_acks(input int n);
        int got = 0;
        for (int k = 0; k < 200 && got < n; k++) begin
            tick();
            if (req_ack != 3'b000) got++;
        end
        check("ack_count", 32'(got), 32'(n));
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 300; k++) begin
            if (tx_exp.size() == 0 && rx_exp.size() == 0 && rx_q.size() == 0) break;
            tick();
        end
        repeat (6) tick();
        check({tag, "_tx_left"}, 32'(tx_exp.size()), 32'd0);
        check({tag, "_rx_left"}, 32'(rx_exp.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c;
        int found;
        rst = 1'b0; req = 3'b000; req_data = 24'h0; tx_full = 1'b0;
        tb_ptr = 2;
        repeat (3) tick();
        check("rst_outputs", 32'({wr_uart, send_uart, req_ack, rd_uart, rx_valid, frame_err, link_lost}), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        rst = 1'b1;
        tick();

        // single frame on ch1, exact strobe timing, payload kept after req drops
        req_data = 24'h002A00;
        req = 3'b010;
        expect_frame(pick(3'b010), 8'h2A);
        tick();
        req = 3'b000;
        tick();
        check("t1_tag_time", 32'(wr_uart), 32'd1);
        tick();
        check("t1_gap", 32'(wr_uart), 32'd0);
        tick();
        check("t1_data_time", 32'({wr_uart, req_ack}), 32'({1'b1, 3'b010}));
        drain("t1");

        // all channels held: round-robin rotation
        req_data = 24'h302010;
        req = 3'b111;
        for (int f = 0; f < 6; f++) begin
            c = pick(3'b111);
            expect_frame(c, 8'((c + 1) * 16));
        end
        wait_acks(6);
        req = 3'b000;
        drain("t2");

        // backpressure in TAG for 5 cycles and DATA for 3 cycles
        req_data = 24'h00005C;
        tx_full = 1'b1;
        req = 3'b001;
        expect_frame(pick(3'b001), 8'h5C);
        tick();
        req = 3'b000;
        repeat (5) begin
            tick();
            check("t3_hold_tag", 32'(wr_uart), 32'd0);
        end
        tx_full = 1'b0;
        tick();
        check("t3_tag_release", 32'(wr_uart), 32'd1);
        tx_full = 1'b1;
        tick();
        check("t3_gap", 32'(wr_uart), 32'd0);
        repeat (3) begin
            tick();
            check("t3_hold_data", 32'(wr_uart), 32'd0);
        end
        tx_full = 1'b0;
        tick();
        check("t3_data_release", 32'({wr_uart, req_ack}), 32'({1'b1, 3'b001}));
        drain("t3");

        // RX parse with framing errors
        rx_exp.push_back('{vld: 3'b100, ferr: 1'b0, ch: 2'd2, d: 8'h7F});
        rx_exp.push_back('{vld: 3'b000, ferr: 1'b1, ch: 2'd0, d: 8'h00});
        rx_exp.push_back('{vld: 3'b000, ferr: 1'b1, ch: 2'd0, d: 8'h00});
        rx_exp.push_back('{vld: 3'b001, ferr: 1'b0, ch: 2'd0, d: 8'hA1});
        rx_q.push_back(8'hA2); rx_q.push_back(8'h7F); rx_q.push_back(8'h55);
        rx_q.push_back(8'hA3); rx_q.push_back(8'hA0); rx_q.push_back(8'hA1);
        drain("t4");
        check("t4_rx_data", 32'(rx_data), 32'h007F00A1);

        // async reset between tag and data of a ch2 frame
        req_data = 24'h330044;
        req = 3'b100;
        c = pick(3'b100);
        tx_exp.push_back('{b: 8'hA0 | 8'(c), ack: 3'b000});
        tick();
        req = 3'b000;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            if (wr_uart) found = 1;
            else tick();
        end
        check("t5_tag_seen", 32'(found), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("t5_async_out", 32'({wr_uart, send_uart, req_ack, rd_uart, rx_valid, frame_err, link_lost}), 32'd0);
        check("t5_async_rx_data", 32'(rx_data), 32'd0);
        req = 3'b101;
        tick();
        tick();
        check("t5_held_out", 32'({wr_uart, send_uart, req_ack}), 32'd0);
        rst = 1'b1;
        tb_ptr = 2;
        expect_frame(pick(3'b101), 8'h44);
        expect_frame(pick(3'b101), 8'h33);
        wait_acks(2);
        req = 3'b000;
        drain("t5");

`ifdef LINK_TIMEOUT_EN
        // RX silence watchdog
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (99) tick();
        check("t6_before_limit", 32'(link_lost), 32'd0);
        tick();
        check("t6_at_limit", 32'(link_lost), 32'd1);
        rx_exp.push_back('{vld: 3'b001, ferr: 1'b0, ch: 2'd0, d: 8'h05});
        rx_q.push_back(8'hA0); rx_q.push_back(8'h05);
        found = 0;
        for (int k = 0; k < 50 && found == 0; k++) begin
            tick();
            if (rx_valid != 3'b000) found = 1;
        end
        check("t6_valid_seen", 32'(found), 32'd1);
        check("t6_lost_at_valid", 32'(link_lost), 32'd1);
        tick();
        check("t6_lost_cleared", 32'(link_lost), 32'd0);
        drain("t6");
`else
        repeat (120) tick();
        check("link_lost_off", 32'(link_lost), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
